dmem_responder: RTL and testbench

- Data-memory responder serving the load/store requests issued by the CPU's MEM stage.
- It is the responder end of the memory interface that the pipeline initiates.
- It accepts one word request at a time through a req/ready handshake, then spends a programmable number of wait cycles before it commits the write or returns read data.
- While a request is outstanding it drives a stall to the pipeline hazard logic. It also flags misaligned and out-of-range accesses.

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: one word request at a time,
// programmable wait latency, stall generation and access-fault reporting.
// Optional build macro: DMEM_BYTE_EN (adds be_i byte-lane store enables).
module dmem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
`ifdef DMEM_BYTE_EN
   input  logic [3:0]  be_i,
`endif
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        stall_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               we_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;
   logic               accept_c;
   logic               access_c;
   logic               fault_c;
   logic [IDX_W-1:0]   idx_c;
   logic [31:0]        mem [DEPTH];

   // Handshake and stall are pure decodes of the state register and req_i
   assign ready_o  = (state_q == S_IDLE);
   assign accept_c = ready_o & req_i;
   assign stall_o  = accept_c | (state_q == S_WAIT);

   // Word index and fault detection on the captured address
   assign idx_c   = addr_q[IDX_W+1:2];
   assign fault_c = (addr_q[1:0] != 2'b00) || (addr_q[31:IDX_W+2] != '0);

   // Next-state logic; the access strobe fires on the last WAIT edge
   always_comb begin
      state_d  = state_q;
      access_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d  = S_DONE;
               access_c = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, wait counter and registered response outputs
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rvalid_o <= 1'b0;
         err_o    <= 1'b0;
         rdata_o  <= '0;
      end else begin
         state_q  <= state_d;
         rvalid_o <= access_c;
         err_o    <= access_c & fault_c;
         if (accept_c) begin
            cnt_q <= CNT_W'(LATENCY - 1);
         end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (access_c) begin
            if (fault_c) begin
               rdata_o <= '0;
            end else if (!we_q) begin
               rdata_o <= mem[idx_c];
            end
         end
      end
   end

   // Request capture at acceptance; later input changes are ignored
   always_ff @(posedge clk_i) begin
      if (accept_c) begin
         we_q    <= we_i;
         addr_q  <= addr_i;
         wdata_q <= wdata_i;
      end
   end

`ifdef DMEM_BYTE_EN
   // Byte-lane enables captured alongside the request
   always_ff @(posedge clk_i) begin
      if (accept_c) begin
         be_q <= be_i;
      end
   end
`else
   assign be_q = 4'hF;
`endif

   // Storage array; a reset at the access edge suppresses the store
   always_ff @(posedge clk_i) begin
      if (rst_i && access_c && we_q && !fault_c) begin
         for (int k = 0; k < 4; k++) begin
            if (be_q[k]) begin
               mem[idx_c][8*k +: 8] <= wdata_q[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: a LATENCY=2/DEPTH=256
// instance and a LATENCY=1/DEPTH=16 instance sharing clock and data inputs.
// Byte-enable checks are built when DMEM_BYTE_EN is defined.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic        we;
   logic [31:0] addr, wdata;
`ifdef DMEM_BYTE_EN
   logic [3:0]  be;
`endif
   logic        ready0, rvalid0, err0, stall0;
   logic [31:0] rdata0;
   logic        ready1, rvalid1, err1, stall1;
   logic [31:0] rdata1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we),
`ifdef DMEM_BYTE_EN
      .be_i(be),
`endif
      .addr_i(addr), .wdata_i(wdata), .ready_o(ready0), .rvalid_o(rvalid0),
      .rdata_o(rdata0), .err_o(err0), .stall_o(stall0)
   );

   dmem_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we),
`ifdef DMEM_BYTE_EN
      .be_i(be),
`endif
      .addr_i(addr), .wdata_i(wdata), .ready_o(ready1), .rvalid_o(rvalid1),
      .rdata_o(rdata1), .err_o(err1), .stall_o(stall1)
   );

   // Count one comparison and report it when it misses
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One request on instance sel; returns data, error, access latency and stall cycles
   task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat, output int stl);
      logic rv, st, done;
      @(negedge clk);
      we = w; addr = a; wdata = d;
      if (sel != 0) req1 = 1'b1; else req0 = 1'b1;
      #1;
      check("txn_ready", (sel != 0) ? ready1 : ready0, 1'b1);
      stl  = ((sel != 0) ? stall1 : stall0) ? 1 : 0;
      lat  = -1;
      rd   = '0;
      er   = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         rv = (sel != 0) ? rvalid1 : rvalid0;
         st = (sel != 0) ? stall1 : stall0;
         if (rv) begin
            lat  = i;
            rd   = (sel != 0) ? rdata1 : rdata0;
            er   = (sel != 0) ? err1 : err0;
            done = 1'b1;
            check("stall_in_done", st, 1'b0);
         end else if (st) begin
            stl++;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check("txn_timeout", done, 1'b1);
   endtask

   logic [31:0] bb_addr [3] = '{32'h40, 32'h44, 32'h40};
   logic        bb_we   [3] = '{1'b1, 1'b0, 1'b0};
   logic [31:0] bb_wd   [3] = '{32'h0BAD_0001, 32'h0, 32'h0};
   logic [31:0] bb_exp  [3] = '{32'h0, 32'h4444_4444, 32'h0BAD_0001};

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, stl, nrv, k, last;

      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef DMEM_BYTE_EN
      be = 4'hF;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready0, 1'b1);
      check("rst_rvalid", rvalid0, 1'b0);
      check("rst_err", err0, 1'b0);
      check("rst_rdata", rdata0, 32'h0);
      check("rst_stall", stall0, 1'b0);
      rst = 1'b1;

      // Store then load
      txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat, stl);
      check("st_lat", lat, 2);
      check("st_stall", stl, 3);
      check("st_err", er, 1'b0);
      txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat, stl);
      check("ld_lat", lat, 2);
      check("ld_stall", stl, 3);
      check("ld_data", rd, 32'hDEAD_BEEF);
      check("ld_err", er, 1'b0);

      // A clean store leaves rdata_o at the last load value
      txn(0, 1'b1, 32'h44, 32'h4444_4444, rd, er, lat, stl);
      check("st_hold_rdata", rd, 32'hDEAD_BEEF);

      // Misaligned store is dropped
      txn(0, 1'b1, 32'h13, 32'h5555_5555, rd, er, lat, stl);
      check("mis_err", er, 1'b1);
      check("mis_rdata", rd, 32'h0);
      txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat, stl);
      check("mis_old_data", rd, 32'hDEAD_BEEF);
      check("mis_old_err", er, 1'b0);

      // Range boundary: 0x400 faults, 0x3FC is the last legal word
      txn(0, 1'b0, 32'h400, 32'h0, rd, er, lat, stl);
      check("oor_err", er, 1'b1);
      check("oor_rdata", rd, 32'h0);
      txn(0, 1'b0, 32'h3FC, 32'h0, rd, er, lat, stl);
      check("last_word_err", er, 1'b0);

      // Reset in WAIT abandons a pending store
      txn(0, 1'b1, 32'h20, 32'h0000_5A5A, rd, er, lat, stl);
      txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat, stl);
      @(negedge clk);
      we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; req0 = 1'b1;
      @(negedge clk);
      check("rw_in_wait", ready0, 1'b0);
      rst = 1'b0; req0 = 1'b0;
      @(negedge clk);
      check("rw_rvalid", rvalid0, 1'b0);
      check("rw_rdata", rdata0, 32'h0);
      rst = 1'b1;
      check("rw_ready", ready0, 1'b1);
      nrv = 0;
      repeat (6) begin
         @(negedge clk);
         if (rvalid0) nrv++;
      end
      check("rw_no_rvalid", nrv, 0);
      txn(0, 1'b0, 32'h20, 32'h0, rd, er, lat, stl);
      check("rw_prior_data", rd, 32'h0000_5A5A);

      // Back-to-back with req held high; inputs scrambled during WAIT
      k = 0; last = 0;
      @(negedge clk);
      we = bb_we[0]; addr = bb_addr[0]; wdata = bb_wd[0]; req0 = 1'b1;
      for (int i = 0; i < 40 && k < 3; i++) begin
         @(negedge clk);
         if (rvalid0) begin
            if (k > 0) check("bb_spacing", cyc - last, 4);
            last = cyc;
            check("bb_err", err0, 1'b0);
            if (!bb_we[k]) check("bb_rdata", rdata0, bb_exp[k]);
            k++;
            if (k < 3) begin
               we = bb_we[k]; addr = bb_addr[k]; wdata = bb_wd[k];
            end else begin
               req0 = 1'b0;
            end
         end else if (!ready0) begin
            we = ~bb_we[k]; addr = 32'h13; wdata = 32'hFFFF_FFFF;
         end
      end
      check("bb_count", k, 3);

      // LATENCY=1, DEPTH=16 instance
      txn(1, 1'b1, 32'h8, 32'hCAFE_F00D, rd, er, lat, stl);
      check("l1_st_lat", lat, 1);
      check("l1_st_stall", stl, 2);
      txn(1, 1'b0, 32'h8, 32'h0, rd, er, lat, stl);
      check("l1_ld_lat", lat, 1);
      check("l1_ld_stall", stl, 2);
      check("l1_ld_data", rd, 32'hCAFE_F00D);
      txn(1, 1'b0, 32'h40, 32'h0, rd, er, lat, stl);
      check("l1_oor_err", er, 1'b1);
      check("l1_oor_rdata", rd, 32'h0);
      txn(1, 1'b0, 32'h3C, 32'h0, rd, er, lat, stl);
      check("l1_last_word_err", er, 1'b0);

`ifdef DMEM_BYTE_EN
      // Byte-lane stores
      be = 4'hF;
      txn(0, 1'b1, 32'h50, 32'hAABB_CCDD, rd, er, lat, stl);
      be = 4'b0101;
      txn(0, 1'b1, 32'h50, 32'h1122_3344, rd, er, lat, stl);
      be = 4'h0;
      txn(0, 1'b0, 32'h50, 32'h0, rd, er, lat, stl);
      check("be_merge", rd, 32'hAA22_CC44);
      txn(0, 1'b1, 32'h50, 32'hFFFF_FFFF, rd, er, lat, stl);
      check("be_zero_err", er, 1'b0);
      txn(0, 1'b0, 32'h50, 32'h0, rd, er, lat, stl);
      check("be_zero_nochange", rd, 32'hAA22_CC44);
      be = 4'hF;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
